wptr_full_multi: RTL

//  Write-side pointer/flag block for the async FIFO, successor to the single-push write pointer.

---
 rtl/wptr_full_multi_pkg.sv | 29 ++
 rtl/wptr_full_multi_if.sv | 39 +++
 rtl/wptr_full_multi.sv | 93 +++++++++
 3 files changed

// File: rtl/wptr_full_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_multi_pkg
//  Brief    : Shared pointer helpers for the async FIFO write side.
//  Revision : 1.0 - initial release
// ============================================================================
package wptr_full_multi_pkg;

    // Helpers work on a fixed wide word; callers zero-extend in and truncate out.
    // Zero extension keeps both conversions exact for any narrower width.
    localparam int C_PTR_MAX_W = 32;

    typedef logic [C_PTR_MAX_W-1:0] wide_ptr_t;

    function automatic wide_ptr_t bin2gray(input wide_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic wide_ptr_t gray2bin(input wide_ptr_t g);
        wide_ptr_t b;
        b[C_PTR_MAX_W-1] = g[C_PTR_MAX_W-1];
        for (int i = C_PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : wptr_full_multi_pkg
`default_nettype wire

// File: rtl/wptr_full_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_multi_if
//  Brief    : Write-side push request / pointer status bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface wptr_full_multi_if #(
    parameter int AW     = 4,
    parameter int PUSH_N = 4
);
    localparam int CW = $clog2(PUSH_N + 1);

    logic          push;
    logic [CW-1:0] push_cnt;
    logic [AW:0]   af_thresh;
    logic          ovf_clr;
    logic [AW:0]   wq2_rptr;

    logic          push_ok;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic [AW:0]   wlevel;
    logic [AW:0]   wfree;
    logic          wfull;
    logic          walmost_full;
    logic          wovf;

    modport master (
        output push, push_cnt, af_thresh, ovf_clr, wq2_rptr,
        input  push_ok, waddr, wptr, wlevel, wfree, wfull, walmost_full, wovf
    );

    modport slave (
        input  push, push_cnt, af_thresh, ovf_clr, wq2_rptr,
        output push_ok, waddr, wptr, wlevel, wfree, wfull, walmost_full, wovf
    );

endinterface : wptr_full_multi_if
`default_nettype wire

// File: rtl/wptr_full_multi.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_multi
//  Brief    : Multi-word write pointer, level, free count and full/overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module wptr_full_multi
    import wptr_full_multi_pkg::*;
#(
    parameter int AW     = 4,
    parameter int PUSH_N = 4
) (
    input  wire                 wclk,
    input  wire                 wrst_n,
    wptr_full_multi_if.slave    bus
);

    localparam int DEPTH = 2 ** AW;

    typedef logic [AW:0] ptr_t;

    localparam ptr_t c_DEPTH = ptr_t'(DEPTH);

    generate
        if (PUSH_N < 1 || PUSH_N > DEPTH) begin : g_bad_push_n
            $error("wptr_full_multi: PUSH_N must lie in 1..2**AW");
        end
    endgenerate

    ptr_t r_wbin;
    ptr_t r_wptr;
    ptr_t r_wlevel;
    ptr_t r_wfree;
    logic r_wfull;
    logic r_walmost_full;
    logic r_wovf;

    ptr_t w_cnt;
    logic w_acc;
    ptr_t w_wbin_next;
    ptr_t w_rbin;
    ptr_t w_lvl_next;

    // Acceptance uses the registered free count only, so a same-cycle read never
    // makes room early; push_ok depends on push/push_cnt and state, nothing else.
    always_comb begin
        w_cnt       = ptr_t'(bus.push_cnt);
        w_acc       = bus.push && (w_cnt <= r_wfree);
        w_wbin_next = r_wbin + (w_acc ? w_cnt : '0);
        w_rbin      = ptr_t'(gray2bin(wide_ptr_t'(bus.wq2_rptr)));
        w_lvl_next  = w_wbin_next - w_rbin;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wlevel       <= '0;
            r_wfree        <= c_DEPTH;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= ptr_t'(bin2gray(wide_ptr_t'(w_wbin_next)));
            r_wlevel       <= w_lvl_next;
            r_wfree        <= c_DEPTH - w_lvl_next;
            r_wfull        <= (w_lvl_next == c_DEPTH);
            r_walmost_full <= (w_lvl_next >= bus.af_thresh);
        end
    end

    // A reject in the same cycle as a clear leaves the flag set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf <= 1'b0;
        end else if (bus.push && !w_acc) begin
            r_wovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_wovf <= 1'b0;
        end
    end

    assign bus.push_ok      = w_acc;
    assign bus.waddr        = r_wbin[AW-1:0];
    assign bus.wptr         = r_wptr;
    assign bus.wlevel       = r_wlevel;
    assign bus.wfree        = r_wfree;
    assign bus.wfull        = r_wfull;
    assign bus.walmost_full = r_walmost_full;
    assign bus.wovf         = r_wovf;

endmodule : wptr_full_multi
`default_nettype wire
